// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues reads to a 1-cycle-latency instruction memory,
// buffers {pc, instr} pairs in a 2-entry FIFO and presents them to decode over a
// valid/ready handshake. Redirects flush the FIFO and any in-flight response.
module instruction_fetch #(
  parameter int unsigned          ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0,
  parameter int unsigned          PC_STEP  = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [31:0]       out_instr
);

  localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(PC_STEP);

  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] pending_pc_r;
  logic              inflight_r;
  logic [1:0]        cnt_r;
  logic [ADDR_W-1:0] head_pc_r;
  logic [31:0]       head_instr_r;
  logic [ADDR_W-1:0] tail_pc_r;
  logic [31:0]       tail_instr_r;

  logic              pop_s;
  logic              push_s;
  logic              req_s;
  logic [2:0]        occ_s;

  // Handshake, capture and issue decisions; occupancy counts the in-flight slot
  // so a response always has room when it lands.
  always_comb begin
    pop_s  = 1'b0;
    push_s = 1'b0;
    req_s  = 1'b0;
    occ_s  = 3'd0;
    pop_s  = (cnt_r != 2'd0) && out_ready;
    push_s = inflight_r && !redirect_valid;
    occ_s  = {1'b0, cnt_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    if (!rst && !redirect_valid && (occ_s < 3'd2)) begin
      req_s = 1'b1;
    end else begin
      req_s = 1'b0;
    end
  end

  assign imem_req  = req_s;
  assign imem_addr = pc_r;
  assign out_valid = (cnt_r != 2'd0);
  assign out_pc    = head_pc_r;
  assign out_instr = head_instr_r;

  // PC, in-flight flag and pending address; a redirect discards the in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r         <= RESET_PC;
      pending_pc_r <= '0;
      inflight_r   <= 1'b0;
    end else if (redirect_valid) begin
      pc_r         <= redirect_pc;
      pending_pc_r <= pending_pc_r;
      inflight_r   <= 1'b0;
    end else if (req_s) begin
      pc_r         <= pc_r + PC_INC;
      pending_pc_r <= pc_r;
      inflight_r   <= 1'b1;
    end else begin
      pc_r         <= pc_r;
      pending_pc_r <= pending_pc_r;
      inflight_r   <= 1'b0;
    end
  end

  // Two-entry shift FIFO: head is always the presented entry, pop shifts tail forward.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r        <= 2'd0;
      head_pc_r    <= '0;
      head_instr_r <= 32'd0;
      tail_pc_r    <= '0;
      tail_instr_r <= 32'd0;
    end else if (redirect_valid) begin
      cnt_r        <= 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          cnt_r <= cnt_r + 2'd1;
          if (cnt_r == 2'd0) begin
            head_pc_r    <= pending_pc_r;
            head_instr_r <= imem_rdata;
          end else begin
            tail_pc_r    <= pending_pc_r;
            tail_instr_r <= imem_rdata;
          end
        end
        2'b01: begin
          cnt_r        <= cnt_r - 2'd1;
          head_pc_r    <= tail_pc_r;
          head_instr_r <= tail_instr_r;
        end
        2'b11: begin
          cnt_r <= cnt_r;
          if (cnt_r == 2'd1) begin
            head_pc_r    <= pending_pc_r;
            head_instr_r <= imem_rdata;
          end else begin
            head_pc_r    <= tail_pc_r;
            head_instr_r <= tail_instr_r;
            tail_pc_r    <= pending_pc_r;
            tail_instr_r <= imem_rdata;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  instruction_fetch_chk #(.ADDR_W(ADDR_W)) u_chk (
    .clk            (clk),
    .rst            (rst),
    .push           (push_s),
    .pop            (pop_s),
    .cnt            (cnt_r),
    .redirect_valid (redirect_valid),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
  );

endmodule

// Simulation checks for the fetch FIFO: no overflow, payload stable under backpressure.
module instruction_fetch_chk #(
  parameter int unsigned ADDR_W = 32
) (
  input logic              clk,
  input logic              rst,
  input logic              push,
  input logic              pop,
  input logic [1:0]        cnt,
  input logic              redirect_valid,
  input logic              out_valid,
  input logic              out_ready,
  input logic [ADDR_W-1:0] out_pc,
  input logic [31:0]       out_instr
);

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (cnt == 2'd2)));

  a_payload_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready && !redirect_valid) |=> ($stable(out_pc) && $stable(out_instr)));

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: streaming, backpressure, redirects, wrap, reset.
module tb_instruction_fetch;

  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_pc;
  logic [31:0]   out_instr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instruction_fetch #(.ADDR_W(AW), .RESET_PC(8'h00), .PC_STEP(1)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
  );

  // Synchronous instruction memory model: mem[a] = 0x100 + a, one-cycle latency.
  always_ff @(posedge clk) begin
    if (imem_req) imem_rdata <= 32'h100 + {24'd0, imem_addr};
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    imem_rdata     = 32'd0;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    out_ready      = 1'b0;
    step(2);
    check_val("rst_valid", 64'(out_valid), 64'd0);
    check_val("rst_pc",    64'(out_pc),    64'd0);
    check_val("rst_instr", 64'(out_instr), 64'd0);
    check_val("rst_req",   64'(imem_req),  64'd0);

    // Streaming from reset with decode always ready.
    out_ready = 1'b1;
    rst = 1'b0;
    #1;
    check_val("s_req0",  64'(imem_req),  64'd1);
    check_val("s_addr0", 64'(imem_addr), 64'd0);
    step(1);
    check_val("s_valid_c1", 64'(out_valid), 64'd0);
    step(1);
    for (int i = 0; i < 5; i++) begin
      check_val("s_valid", 64'(out_valid), 64'd1);
      check_val("s_pc",    64'(out_pc),    64'(i));
      check_val("s_instr", 64'(out_instr), 64'(32'h100 + i));
      step(1);
    end

    // Redirect with a pop of head pc 5 in the same cycle.
    check_val("rp_head5", 64'(out_pc), 64'd5);
    redirect_valid = 1'b1;
    redirect_pc    = 8'h20;
    #1;
    check_val("rp_noreq", 64'(imem_req), 64'd0);
    step(1);
    redirect_valid = 1'b0;
    #1;
    check_val("rp_valid0", 64'(out_valid), 64'd0);
    check_val("rp_req",    64'(imem_req),  64'd1);
    check_val("rp_addr",   64'(imem_addr), 64'h20);
    step(1);
    check_val("rp_valid1", 64'(out_valid), 64'd0);
    step(1);
    check_val("rp_tvalid", 64'(out_valid), 64'd1);
    check_val("rp_tpc",    64'(out_pc),    64'h20);
    check_val("rp_tinstr", 64'(out_instr), 64'h120);
    step(1);
    check_val("rp_next",   64'(out_pc),    64'h21);

    // PC wrap at 8-bit address width.
    redirect_valid = 1'b1;
    redirect_pc    = 8'hFF;
    step(1);
    redirect_valid = 1'b0;
    step(2);
    check_val("w_pcff",    64'(out_pc),    64'hFF);
    check_val("w_instrff", 64'(out_instr), 64'h1FF);
    step(1);
    check_val("w_valid00", 64'(out_valid), 64'd1);
    check_val("w_pc00",    64'(out_pc),    64'h00);
    check_val("w_instr00", 64'(out_instr), 64'h100);

    // Back-to-back redirects: the last one wins.
    redirect_valid = 1'b1;
    redirect_pc    = 8'h10;
    step(1);
    redirect_pc    = 8'h30;
    step(1);
    redirect_valid = 1'b0;
    #1;
    check_val("bb_addr",  64'(imem_addr), 64'h30);
    check_val("bb_valid", 64'(out_valid), 64'd0);
    step(2);
    check_val("bb_pc",    64'(out_pc),    64'h30);
    check_val("bb_instr", 64'(out_instr), 64'h130);

    // Backpressure from reset: FIFO fills with pcs 0,1 and issue stops at pc 2.
    rst = 1'b1;
    out_ready = 1'b0;
    step(1);
    rst = 1'b0;
    step(3);
    check_val("bp_valid", 64'(out_valid), 64'd1);
    check_val("bp_pc0",   64'(out_pc),    64'd0);
    check_val("bp_noreq", 64'(imem_req),  64'd0);
    check_val("bp_addr",  64'(imem_addr), 64'd2);
    step(1);
    check_val("bp_hold",  64'(out_pc),    64'd0);
    out_ready = 1'b1;
    #1;
    check_val("bp_req",   64'(imem_req),  64'd1);
    for (int i = 1; i < 4; i++) begin
      step(1);
      check_val("bp_valid_n", 64'(out_valid), 64'd1);
      check_val("bp_pc_n",    64'(out_pc),    64'(i));
    end

    // Redirect with one entry buffered and one read in flight.
    rst = 1'b1;
    out_ready = 1'b0;
    step(1);
    rst = 1'b0;
    step(2);
    check_val("rd_pc0",  64'(out_pc),   64'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 8'h40;
    step(1);
    redirect_valid = 1'b0;
    #1;
    check_val("rd_valid0", 64'(out_valid), 64'd0);
    check_val("rd_req",    64'(imem_req),  64'd1);
    check_val("rd_addr",   64'(imem_addr), 64'h40);
    step(1);
    check_val("rd_valid1", 64'(out_valid), 64'd0);
    step(1);
    check_val("rd_pc40",    64'(out_pc),    64'h40);
    check_val("rd_instr40", 64'(out_instr), 64'h140);
    out_ready = 1'b1;
    step(1);
    check_val("rd_pc41", 64'(out_pc), 64'h41);
    step(1);
    check_val("rd_pc42", 64'(out_pc), 64'h42);

    // Reset while a read is in flight and the FIFO holds an entry.
    rst = 1'b1;
    out_ready = 1'b0;
    step(1);
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    #1;
    check_val("mr_req_in_rst", 64'(imem_req), 64'd0);
    step(1);
    check_val("mr_valid", 64'(out_valid), 64'd0);
    check_val("mr_pc",    64'(out_pc),    64'd0);
    check_val("mr_req",   64'(imem_req),  64'd0);
    rst = 1'b0;
    #1;
    check_val("mr_req1",  64'(imem_req),  64'd1);
    check_val("mr_addr",  64'(imem_addr), 64'd0);
    step(1);
    check_val("mr_valid1", 64'(out_valid), 64'd0);
    step(1);
    check_val("mr_valid2", 64'(out_valid), 64'd1);
    check_val("mr_pc0",    64'(out_pc),    64'd0);
    check_val("mr_instr0", 64'(out_instr), 64'h100);
    step(1);
    check_val("mr_hold",   64'(out_pc),    64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
